// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers for the flushable synchronous FIFO
package fifo_pkg;
  function automatic int FIFO_PTR_W(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
  function automatic int FIFO_CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: pointer that wraps from DEPTH-1 to 0 for any DEPTH, with synchronous clear
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         clr,
  output logic [FIFO_PTR_W(DEPTH)-1:0] ptr
);
  localparam int PW = FIFO_PTR_W(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  // clear wins over increment; explicit wrap keeps non-power-of-two depths legal
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/sync_fifo_flush.sv
// sync_fifo_flush: show-ahead synchronous FIFO with flush; FIFO_ERR_FLAGS_EN adds sticky ovf/udf
module sync_fifo_flush
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pull,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         empty,
  output logic                         full,
  output logic                         afull,
  output logic                         aempty,
  output logic [FIFO_CNT_W(DEPTH)-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                         ovf,
  output logic                         udf
`endif
);
  localparam int PW = FIFO_PTR_W(DEPTH);
  localparam int CW = FIFO_CNT_W(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  if (DEPTH < 2 || !(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_params
    $error("sync_fifo_flush: need DEPTH>=2 and AEMPTY_TH<AFULL_TH<=DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t rd_ptr, wr_ptr;
  cnt_t count_nxt;
  logic rd_en, wr_en;

  // a full FIFO still takes a write when the head is popped in the same cycle
  always_comb begin
    rd_en = pull && !empty;
    wr_en = push && (!full || rd_en);
    count_nxt = flush ? '0 : count + cnt_t'(wr_en) - cnt_t'(rd_en);
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .rst(rst), .inc(rd_en), .clr(flush), .ptr(rd_ptr)
  );
  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .rst(rst), .inc(wr_en), .clr(flush), .ptr(wr_ptr)
  );

  // storage is never reset; a flushed write is dropped
  always_ff @(posedge clk)
    if (wr_en && !flush) mem[wr_ptr] <= data_in;

  assign data_out = mem[rd_ptr];

  // occupancy and status flags registered from the next-state count
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      aempty <= 1'b1;
      afull  <= 1'(AFULL_TH == 0);
    end else begin
      count  <= count_nxt;
      empty  <= count_nxt == '0;
      full   <= count_nxt == cnt_t'(DEPTH);
      aempty <= count_nxt <= cnt_t'(AEMPTY_TH);
      afull  <= count_nxt >= cnt_t'(AFULL_TH);
    end

`ifdef FIFO_ERR_FLAGS_EN
  // sticky error flags: set on an ignored request, cleared by flush or reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && !wr_en) ovf <= 1'b1;
      if (pull && empty) udf <= 1'b1;
    end
`endif
endmodule
